// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy flags, sticky errors and flush.
// Define PARAM_SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise registered read.
module param_sync_fifo #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wr_acc;
  logic                  rd_acc;

  // A separate count register gives true full-depth occupancy without an extra pointer bit.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately not reset; words are only reachable through the pointers.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) mem[wr_ptr] <= data_in;
  end

  // A fresh error in the same cycle as clr_err takes precedence over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

`ifdef PARAM_SYNC_FIFO_FWFT_EN
  assign data_out   = mem[rd_ptr];
  assign data_valid = ~empty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out   <= '0;
      data_valid <= 1'b0;
    end else if (flush) begin
      data_valid <= 1'b0;
    end else if (rd_acc) begin
      data_out   <= mem[rd_ptr];
      data_valid <= 1'b1;
    end else begin
      data_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_param_sync_fifo;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        wr_en;
  logic [63:0] data_in;
  logic        rd_en;
  logic [63:0] data_out;
  logic        data_valid;
  logic        full;
  logic        empty;
  logic        almost_full;
  logic        almost_empty;
  logic [4:0]  count;
  logic        overflow;
  logic        underflow;
  logic        clr_err;

  int compared = 0;
  int failed   = 0;

  // Reference model state: FIFO contents as a queue plus the observable registers.
  logic [63:0] q[$];
  logic [63:0] exp_dout;
  logic        exp_dv;
  logic        exp_ovf;
  logic        exp_udf;

  typedef struct {
    logic        wr;
    logic [63:0] din;
    logic        rd;
    logic        fl;
    logic        ce;
    int          ecount;
    logic        efull;
    logic        eempty;
    logic        eovf;
    logic        eudf;
  } vec_t;
  vec_t vecs[11];

  param_sync_fifo #(
    .DATA_WIDTH(64),
    .ADDR_WIDTH(4),
    .AF_THRESH(AF),
    .AE_THRESH(AE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .wr_en(wr_en),
    .data_in(data_in),
    .rd_en(rd_en),
    .data_out(data_out),
    .data_valid(data_valid),
    .full(full),
    .empty(empty),
    .almost_full(almost_full),
    .almost_empty(almost_empty),
    .count(count),
    .overflow(overflow),
    .underflow(underflow),
    .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
    compared++;
    if (act !== req) begin
      failed++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic resetModel();
    q.delete();
    exp_dout = '0;
    exp_dv   = 1'b0;
    exp_ovf  = 1'b0;
    exp_udf  = 1'b0;
  endtask

  // One clock edge of FIFO behaviour, evaluated from the pre-edge occupancy.
  task automatic modelStep(input logic wr, input logic [63:0] din, input logic rd,
                           input logic fl, input logic ce);
    int n;
    logic [63:0] popped;
    n = q.size();
    if (ce) begin
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
    end
    if (wr && n == DEPTH) exp_ovf = 1'b1;
    if (rd && n == 0)     exp_udf = 1'b1;
    if (fl) begin
      q.delete();
      exp_dv = 1'b0;
    end else begin
      exp_dv = 1'b0;
      if (rd && n != 0) begin
        popped   = q.pop_front();
        exp_dout = popped;
        exp_dv   = 1'b1;
      end
      if (wr && n != DEPTH) q.push_back(din);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [63:0] din, input logic rd,
                               input logic fl, input logic ce);
    wr_en   = wr;
    data_in = din;
    rd_en   = rd;
    flush   = fl;
    clr_err = ce;
    modelStep(wr, din, rd, fl, ce);
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    flush   = 1'b0;
    clr_err = 1'b0;
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = q.size();
    cmp({tag, ".count"},        64'(count),        64'(n));
    cmp({tag, ".full"},         64'(full),         64'(n == DEPTH));
    cmp({tag, ".empty"},        64'(empty),        64'(n == 0));
    cmp({tag, ".almost_full"},  64'(almost_full),  64'(n >= AF));
    cmp({tag, ".almost_empty"}, 64'(almost_empty), 64'(n <= AE));
    cmp({tag, ".overflow"},     64'(overflow),     64'(exp_ovf));
    cmp({tag, ".underflow"},    64'(underflow),    64'(exp_udf));
`ifdef PARAM_SYNC_FIFO_FWFT_EN
    cmp({tag, ".data_valid"}, 64'(data_valid), 64'(n != 0));
    if (n != 0) cmp({tag, ".data_out"}, data_out, q[0]);
`else
    cmp({tag, ".data_valid"}, 64'(data_valid), 64'(exp_dv));
    cmp({tag, ".data_out"},   data_out,        exp_dout);
`endif
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic wr;
    logic rd;
    int   n;

    vecs[0]  = '{1'b1, 64'h11, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 64'h22, 1'b0, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 64'h33, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 64'h44, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 64'h0,  1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 64'h0,  1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    resetModel();
    checkOutput("reset");
    rst = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].din, vecs[i].rd, vecs[i].fl, vecs[i].ce);
      checkOutput($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d.tbl_count", i), 64'(count), 64'(vecs[i].ecount));
      cmp($sformatf("vec%0d.tbl_full", i), 64'(full), 64'(vecs[i].efull));
      cmp($sformatf("vec%0d.tbl_empty", i), 64'(empty), 64'(vecs[i].eempty));
      cmp($sformatf("vec%0d.tbl_ovf", i), 64'(overflow), 64'(vecs[i].eovf));
      cmp($sformatf("vec%0d.tbl_udf", i), 64'(underflow), 64'(vecs[i].eudf));
    end

    $display("[TB] asynchronous reset mid-stream");
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 64'(100 + i), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset");
    cmp("pre_reset.count5", 64'(count), 64'd5);
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkOutput("async_reset");
    cmp("async_reset.data_out0", data_out, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_release");

    $display("[TB] fill to full");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 64'(i), 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d", i));
    end
    cmp("fill.full", 64'(full), 64'd1);
    cmp("fill.count16", 64'(count), 64'd16);
    applyStimulus(1'b1, 64'hDEAD, 1'b0, 1'b0, 1'b0);
    checkOutput("fill_overflow");
    cmp("fill.overflow", 64'(overflow), 64'd1);

    $display("[TB] drain to empty");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput($sformatf("drain%0d", i));
`ifndef PARAM_SYNC_FIFO_FWFT_EN
      cmp($sformatf("drain%0d.word", i), data_out, 64'(i));
`endif
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("drain_underflow");
    cmp("drain.underflow", 64'(underflow), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("clr_err");

    $display("[TB] simultaneous read and write");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, rnd64(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd64(), 1'b1, 1'b0, 1'b0);
    checkOutput("both_full");
    cmp("both_full.count15", 64'(count), 64'd15);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH - 1; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd64(), 1'b1, 1'b0, 1'b0);
    checkOutput("both_empty");
    cmp("both_empty.count1", 64'(count), 64'd1);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, rnd64(), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, rnd64(), 1'b1, 1'b0, 1'b0);
    checkOutput("both_mid");
    cmp("both_mid.count7", 64'(count), 64'd7);

    $display("[TB] pointer wrap with occupancy 3..12");
    for (int i = 0; i < 40; i++) begin
      n = q.size();
      if (n <= 3)       begin wr = 1'b1; rd = 1'b0; end
      else if (n >= 12) begin wr = 1'b0; rd = 1'b1; end
      else begin
        wr = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
      end
      applyStimulus(wr, rnd64(), rd, 1'b0, 1'b0);
      checkOutput($sformatf("wrap%0d", i));
    end

    $display("[TB] flush with pending write");
    while (q.size() < 9) applyStimulus(1'b1, rnd64(), 1'b0, 1'b0, 1'b0);
    while (q.size() > 9) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'hF1F1, 1'b0, 1'b1, 1'b0);
    checkOutput("flush");
    cmp("flush.count0", 64'(count), 64'd0);
    cmp("flush.empty", 64'(empty), 64'd1);
    applyStimulus(1'b1, 64'hABC, 1'b0, 1'b0, 1'b0);
    checkOutput("post_flush_wr");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
    checkOutput("post_flush_rd");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = ((i / 50) % 2 == 0) ? 70 : 30;
      applyStimulus(1'($urandom_range(0, 99) < wp), rnd64(),
                    1'($urandom_range(0, 99) < (100 - wp)),
                    1'($urandom_range(0, 99) < 2),
                    1'($urandom_range(0, 99) < 5));
      checkOutput($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
